// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU slice.
//   - opcode (instruction[31:26]) and R-type funct (instruction[5:0]) values
//   - flag bit positions within the 3-bit flags vector
//   - operand-select helper shared by decode logic
package alu_pkg;

    localparam int DATA_W = 32;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Flag bit positions
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_LT   = 1;
    localparam int FLAG_ZERO = 0;

    // Only bit 0 of a register field addresses the two-entry operand file.
    function automatic logic [DATA_W-1:0] sel_operand(input logic            sel,
                                                      input logic [DATA_W-1:0] rega,
                                                      input logic [DATA_W-1:0] regb);
        return sel ? regb : rega;
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: bundles the ALU instruction/operand inputs and registered outputs.
//   instruction [31:0] - MIPS-format instruction
//   regA, regB  [31:0] - operand registers at addresses 0 and 1
//   result      [31:0] - registered result
//   flags       [2:0]  - registered {overflow, less-than, zero}
// master drives instruction/operands; slave (the ALU) drives result/flags.
interface alu_if;
    logic [31:0] instruction;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [31:0] result;
    logic [2:0]  flags;

    modport master (output instruction, output regA, output regB,
                    input  result,      input  flags);
    modport slave  (input  instruction, input  regA, input  regB,
                    output result,      output flags);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational decode + datapath.
//   instruction, regA, regB in; result and flags (unregistered) out.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    logic [5:0]  op, funct;
    logic [4:0]  shamt;
    logic [31:0] opa, opb, imm_s, imm_z;
    logic [31:0] sum_rr, sum_ri, diff;
    logic        ovf_add, ovf_addi, ovf_sub;
    logic        ovf, lt, zero;
    logic        unused_bits;

    assign op    = instruction[31:26];
    assign funct = instruction[5:0];
    assign shamt = instruction[10:6];
    assign opa   = sel_operand(instruction[21], regA, regB);
    assign opb   = sel_operand(instruction[16], regA, regB);
    assign imm_s = {{16{instruction[15]}}, instruction[15:0]};
    assign imm_z = {16'h0000, instruction[15:0]};

    // Upper bits of rs/rt do not address anything.
    assign unused_bits = ^{instruction[25:22], instruction[20:17]};

    assign sum_rr = opa + opb;
    assign sum_ri = opa + imm_s;
    assign diff   = opa - opb;

    // Signed overflow: sign of result disagrees with like-signed inputs.
    assign ovf_add  = (opa[31] == opb[31])   && (sum_rr[31] != opa[31]);
    assign ovf_addi = (opa[31] == imm_s[31]) && (sum_ri[31] != opa[31]);
    assign ovf_sub  = (opa[31] != opb[31])   && (diff[31]   != opa[31]);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        lt     = 1'b0;
        zero   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin result = sum_rr; ovf = ovf_add; end
                    FN_ADDU: result = sum_rr;
                    FN_SUB:  begin result = diff; ovf = ovf_sub; end
                    FN_SUBU: result = diff;
                    FN_AND:  result = opa & opb;
                    FN_OR:   result = opa | opb;
                    FN_XOR:  result = opa ^ opb;
                    FN_NOR:  result = ~(opa | opb);
                    FN_SLT:  lt = $signed(opa) < $signed(opb);
                    FN_SLTU: lt = opa < opb;
                    FN_SLL:  result = opb << shamt;
                    FN_SRL:  result = opb >> shamt;
                    FN_SRA:  result = $signed(opb) >>> shamt;
                    FN_SLLV: result = opb << opa[4:0];
                    FN_SRLV: result = opb >> opa[4:0];
                    FN_SRAV: result = $signed(opb) >>> opa[4:0];
                    default: result = '0;
                endcase
            end
            OP_ADDI:  begin result = sum_ri; ovf = ovf_addi; end
            OP_ADDIU: result = sum_ri;
            OP_SLTI:  lt = $signed(opa) < $signed(imm_s);
            OP_SLTIU: lt = opa < imm_s;
            OP_ANDI:  result = opa & imm_z;
            OP_ORI:   result = opa | imm_z;
            OP_XORI:  result = opa ^ imm_z;
            OP_BEQ, OP_BNE: begin result = diff; zero = (opa == opb); end
            OP_LW, OP_SW:   result = sum_ri;
            default:  result = '0;
        endcase
        // Set-less-than ops return the comparison as a 0/1 value.
        if (lt) result = 32'd1;
        flags            = '0;
        flags[FLAG_OVF]  = ovf;
        flags[FLAG_LT]   = lt;
        flags[FLAG_ZERO] = zero;
    end

endmodule

// File: rtl/alu.sv
// alu: 32-bit MIPS-style ALU with a one-cycle registered output.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears result/flags
//   bus   - alu_if.slave: instruction/regA/regB in, result/flags out
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    logic [31:0] result_d, result_q;
    logic [2:0]  flags_d,  flags_q;

    alu_core u_core (
        .instruction (bus.instruction),
        .regA        (bus.regA),
        .regB        (bus.regB),
        .result      (result_d),
        .flags       (flags_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    typedef struct {
        string       name;
        logic [31:0] r;
        logic [2:0]  f;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'b000000, rs, rt, 5'd0, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic sovf(input longint t);
        return (t > 64'sd2147483647) || (t < -64'sd2147483648);
    endfunction

    // Reference model: signed math done in 64 bits, overflow = out of 32-bit range.
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] r, output logic [2:0] f);
        logic [31:0] x, y, se, ze;
        longint      sx, sy, sse, t;
        x   = ins[21] ? b : a;
        y   = ins[16] ? b : a;
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0000, ins[15:0]};
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        sse = longint'($signed(se));
        r = 32'd0;
        f = 3'b000;
        if (ins[31:26] == 6'b000000) begin
            case (ins[5:0])
                6'b100000: begin t = sx + sy; r = t[31:0]; f[2] = sovf(t); end
                6'b100001: r = x + y;
                6'b100010: begin t = sx - sy; r = t[31:0]; f[2] = sovf(t); end
                6'b100011: r = x - y;
                6'b100100: r = x & y;
                6'b100101: r = x | y;
                6'b100110: r = x ^ y;
                6'b100111: r = ~(x | y);
                6'b101010: begin f[1] = (sx < sy); r = {31'd0, f[1]}; end
                6'b101011: begin f[1] = (x < y);   r = {31'd0, f[1]}; end
                6'b000000: r = y << ins[10:6];
                6'b000010: r = y >> ins[10:6];
                6'b000011: begin t = sy >>> ins[10:6]; r = t[31:0]; end
                6'b000100: r = y << x[4:0];
                6'b000110: r = y >> x[4:0];
                6'b000111: begin t = sy >>> x[4:0]; r = t[31:0]; end
                default:   r = 32'd0;
            endcase
        end else begin
            case (ins[31:26])
                6'b001000: begin t = sx + sse; r = t[31:0]; f[2] = sovf(t); end
                6'b001001: r = x + se;
                6'b001010: begin f[1] = (sx < sse); r = {31'd0, f[1]}; end
                6'b001011: begin f[1] = (x < se);   r = {31'd0, f[1]}; end
                6'b001100: r = x & ze;
                6'b001101: r = x | ze;
                6'b001110: r = x ^ ze;
                6'b000100, 6'b000101: begin r = x - y; f[0] = (x == y); end
                6'b100011, 6'b101011: r = x + se;
                default:   r = 32'd0;
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] ar, input logic [2:0] af,
                         input logic [31:0] er, input logic [2:0] ef);
        checks++;
        if (ar !== er || af !== ef) begin
            errors++;
            $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                     name, ar, af, er, ef);
        end
    endtask

    // Drive one instruction on the falling edge and queue its expected response.
    task automatic issue(input string name, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef);
        exp_t e;
        @(negedge clk);
        bus.instruction = ins;
        bus.regA        = a;
        bus.regB        = b;
        e.name = name;
        e.r    = er;
        e.f    = ef;
        sb.push_back(e);
    endtask

    task automatic issue_model(input string name, input logic [31:0] ins,
                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic [2:0]  ef;
        ref_model(ins, a, b, er, ef);
        issue(name, ins, a, b, er, ef);
    endtask

    // Monitor: each registered output corresponds to the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, bus.result, bus.flags, e.r, e.f);
        end
    end

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        logic [5:0]  rfn [16];
        logic [5:0]  iop [11];
        logic [31:0] ins, a, b;
        exp_t        e;
        rfn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                6'b000011, 6'b000100, 6'b000110, 6'b000111};
        iop = '{6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
                6'b001110, 6'b000100, 6'b000101, 6'b100011, 6'b101011};

        bus.instruction = 32'h0;
        bus.regA        = 32'h0;
        bus.regB        = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_state", bus.result, bus.flags, 32'h0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_ovf",  rtype(0, 1, 0, 6'b100000), 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 3'b100);
        issue("addu",     rtype(0, 1, 0, 6'b100001), 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 3'b000);
        issue("addi_ovf", itype(6'b001000, 1, 0, 16'h0001), 32'h0, 32'h7FFFFFFF, 32'h80000000, 3'b100);
        issue("sub",      rtype(0, 1, 0, 6'b100010), 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 3'b000);
        issue("beq_eq",   itype(6'b000100, 0, 1, 16'h0), 32'hFFF00FFF, 32'hFFF00FFF, 32'h0, 3'b001);
        issue("bne_ne",   itype(6'b000101, 0, 1, 16'h0), 32'hFFF00FFF, 32'hFFF00FFE, 32'h1, 3'b000);
        issue("slti",     itype(6'b001010, 0, 0, 16'h802B), 32'h0000000F, 32'h0, 32'h0, 3'b000);
        issue("sltiu",    itype(6'b001011, 0, 0, 16'h002B), 32'h0000000F, 32'h0, 32'h1, 3'b010);
        issue("sllv",     rtype(0, 1, 0, 6'b000100), 32'h8, 32'hFFF00FFF, 32'hF00FFF00, 3'b000);
        issue("sra",      rtype(0, 1, 4, 6'b000011), 32'h8, 32'hFFF00FFF, 32'hFFFF00FF, 3'b000);
        issue("srav",     rtype(0, 1, 0, 6'b000111), 32'h8, 32'hFFF00FFF, 32'hFFFFF00F, 3'b000);
        issue("srl",      rtype(0, 1, 4, 6'b000010), 32'h8, 32'hFFF00FFF, 32'h0FFF00FF, 3'b000);
        issue("srlv",     rtype(0, 1, 0, 6'b000110), 32'h8, 32'hFFF00FFF, 32'h00FFF00F, 3'b000);
        issue("andi",     itype(6'b001100, 0, 0, 16'hFFFF), 32'hFFFFFFFF, 32'h0, 32'h0000FFFF, 3'b000);
        issue("sw",       itype(6'b101011, 1, 0, 16'h0000), 32'h0, 32'h8000000F, 32'h8000000F, 3'b000);
        issue("bad_funct", rtype(0, 1, 0, 6'b111111), 32'h12345678, 32'h9ABCDEF0, 32'h0, 3'b000);
        issue("bad_op",   itype(6'b111111, 0, 1, 16'h1234), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'b000);

        // Mid-stream reset: outputs nonzero, a new instruction pending.
        issue("pre_reset", rtype(0, 1, 0, 6'b100001), 32'h11111111, 32'h22222222, 32'h33333333, 3'b000);
        @(posedge clk);
        #2;
        bus.instruction = rtype(0, 1, 0, 6'b100000);
        bus.regA        = 32'h7FFFFFFF;
        bus.regB        = 32'h1;
        #1 rst_n = 1'b0;
        sb.delete();
        #1 check("async_reset", bus.result, bus.flags, 32'h0, 3'b000);
        @(posedge clk);
        #1 check("held_reset", bus.result, bus.flags, 32'h0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.instruction = rtype(1, 0, 0, 6'b100010);
        bus.regA        = 32'h5;
        bus.regB        = 32'hA;
        e.name = "first_after_reset";
        e.r    = 32'h5;
        e.f    = 3'b000;
        sb.push_back(e);

        for (int i = 0; i < 300; i++) begin
            ins = $urandom();
            case ($urandom_range(0, 9))
                0:       ;
                1, 2, 3, 4: begin
                    ins[31:26] = 6'b000000;
                    ins[5:0]   = rfn[$urandom_range(0, 15)];
                end
                default: ins[31:26] = iop[$urandom_range(0, 10)];
            endcase
            a = rand_operand();
            b = ($urandom_range(0, 5) == 0) ? a : rand_operand();
            issue_model($sformatf("rand%0d_%h", i, ins), ins, a, b);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instruction  input  32  MIPS-format instruction: op[31:26] rs[25:21] rt[20:16] shamt[10:6] funct[5:0] imm[15:0].
REQ-006 regA  input  32  register operand at address 0.
REQ-007 regB  input  32  register operand at address 1.
REQ-008 result  output  32  registered ALU result.
REQ-009 flags  output  3  registered flags: [2] overflow, [1] less-than, [0] zero.

Function
REQ-010 Operand select: rs/rt field bit 0 chooses the operand, 0 selecting regA and 1 selecting regB; bits [4:1] are ignored; opA = sel(rs), opB = sel(rt).
REQ-011 Outputs SHALL be computed combinationally from the current inputs and registered on each rising clk edge; latency is exactly 1 cycle, and a new instruction is accepted every cycle.
REQ-012 R-type (op=000000) by funct: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111.
REQ-013 I-type by op: addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, beq 000100, bne 000101, lw 100011, sw 101011.
REQ-014 Immediates: sign-extended for addi, addiu, slti, sltiu, lw, sw; zero-extended for andi, ori, xori.
REQ-015 add/addu/addi/addiu: result = opA + operand, modulo 2^32; sub/subu: result = opA - opB, modulo 2^32.
REQ-016 flags[2] = 1 only for add, addi and sub when two's-complement signed overflow occurs; it is 0 for the unsigned variants and all other ops.
REQ-017 slt/slti compare signed and sltu/sltiu compare unsigned (opA vs opB or immediate); result = {31'b0, less}, and flags[1] = less; flags[1] is 0 for all other ops.
REQ-018 beq/bne: result = opA - opB; flags[0] = 1 when opA == opB, for both opcodes; flags[0] is 0 for all other ops.
REQ-019 Shifts operate on opB (rt); amount = shamt for sll/srl/sra and opA[4:0] for the variable forms; sra/srav are arithmetic.
REQ-020 lw/sw: result = opA + sext(imm), which is the effective address; no flags are set.
REQ-021 Unsupported op/funct: result = 0, flags = 000.
REQ-022 Any flag bit not defined for the current op SHALL be 0.

Reset
REQ-023 While rst_n = 0, result SHALL be 0 and flags SHALL be 000, asynchronously and independent of clk.
REQ-024 After rst_n deasserts, the first rising edge SHALL register the current instruction.
REQ-025 Reset asserted mid-stream SHALL discard the pending result with no stale output.

Structure
REQ-026 A shared package alu_pkg SHALL hold the opcode and funct localparams and the flag bit indices (FLAG_OVF=2, FLAG_LT=1, FLAG_ZERO=0).
REQ-027 A combinational sub-module alu_core SHALL contain the decode and datapath; alu SHALL wrap it with the output register.

Verification
REQ-028 add: regA=FFFFFFFF, regB=80000000 -> result 7FFFFFFF, flags 100 one cycle later; addu with the same operands -> 7FFFFFFF, flags 000.
REQ-029 addi, rs=1: regB=7FFFFFFF, imm=1 -> result 80000000, flags 100; sub: regA=FFFFFFFF, regB=80000000 -> 7FFFFFFF, flags 000.
REQ-030 beq with equal operands FFF00FFF -> flags 001; bne with FFF00FFF vs FFF00FFE -> flags 000; slti: regA=0000000F, imm=802B -> flags 000; sltiu: same regA, imm=002B -> flags 010.
REQ-031 Shifts with regA=00000008, regB=FFF00FFF, shamt=4: sllv -> F00FFF00, sra -> FFFF00FF, srav -> FFFFF00F, srl -> 0FFF00FF, srlv -> 00FFF00F.
REQ-032 andi: regA=FFFFFFFF, imm=FFFF -> 0000FFFF; sw, rs=1: regB=8000000F -> 8000000F; an illegal funct (e.g. 111111) -> result 0, flags 000.
REQ-033 Assert rst_n low between clock edges while outputs are nonzero -> result and flags go to 0 immediately, and the next instruction after release appears one cycle later.
